xbus_master_port: RTL and testbench
===================================

# xbus_master_port

Per-master request port that sits directly upstream of the simple system bus. It accepts one load/store from a core-side requester, raises this master's request bit into the bus arbiter's `devices_in` vector, waits for grant, drives address/data/write-enable, and returns the slave's read data or an error to the requester. The same module is instantiated once per bus master, for example core LSU, instruction fetch, or DMA.

## Interface
Parameters:
- `MASTER_ID`, default 0: bit index this port occupies in the arbiter request vector. The granted ID is compared against it. Legal range 0..30.
- `TIMEOUT_CYCLES`, default 15: 8-bit limit on cycles spent in REQ+XFER before aborting. Used only with the timeout feature.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_in` in 1: core requests a transfer. Sampled only in IDLE.
- `we_in` in 1: 1 = write, 0 = read.
- `addr_in` in 32: transfer address. Bits [31:27] are the device ID; bits [26:0] are the device address.
- `wdata_in` in 32: write data.
- `stall_out` out 1: port busy; the core must hold off.
- `ready_out` out 1: one-cycle completion pulse.
- `rdata_out` out 32: read data, valid while `ready_out`=1.
- `err_out` out 1: completion was a timeout, valid while `ready_out`=1.
- `bus_req_out` out 1: request bit, wired to `devices_in[MASTER_ID]`.
- `bus_master_id_in` in 5: granted master ID from the bus.
- `bus_hold_in` in 1: bus held (1 = HoldEnable).
- `bus_addr_out` out 32: address to the bus.
- `bus_data_out` out 32: write data to the bus.
- `bus_we_out` out 1: write strobe.
- `bus_data_in` in 32: slave read data.
- `bus_ack_in` in 1: slave completion.

## Operation
- Grant definition: `grant` = `bus_hold_in` & (`bus_master_id_in` == `MASTER_ID`). It is combinational.
- States:
  - IDLE: `req_in`=1 latches addr, wdata and we, then moves to REQ.
  - REQ: `bus_req_out`=1. If `grant`=1, move to XFER.
  - XFER: `bus_req_out`=1 and `bus_we_out`=latched we.
    - `bus_ack_in`=1: capture `bus_data_in` into `rdata_out`, then move to DONE.
    - `grant`=0 without ack (grant lost): return to REQ. The latched request is kept and the timeout counter is not cleared.
  - DONE: `ready_out`=1 and `bus_req_out`=0, then move to IDLE.
- Ack takes priority over grant loss when both occur in the same cycle.
- `bus_addr_out` and `bus_data_out` carry the latched values whenever state≠IDLE. In IDLE they are 0.
- `stall_out` = (state≠IDLE) | `req_in`.
- `req_in` outside IDLE is ignored. Requesters hold `req_in` until `ready_out`.
- For writes, `rdata_out` is the captured `bus_data_in` and is don't-care.
- Reset values: state IDLE. `bus_req_out`, `bus_we_out`, `ready_out`, `err_out` = 0. `rdata_out`, `bus_addr_out`, `bus_data_out` = 0. Timeout counter = 0.
- Reset mid-transfer: all outputs take their reset values on the next edge. The request is dropped and no `ready_out` is issued.

## Timing
- Cycle 0: IDLE sees `req_in`.
- Cycle 1: REQ, `bus_req_out`=1. The bus registers the ID at the end of cycle 1.
- Cycle 2: `grant` becomes visible.
- Cycle 3: XFER. The bus registers addr/data at the end of cycle 3.
- Cycle 4: earliest `bus_ack_in`.
- Cycle 5: DONE, `ready_out`=1.
- Minimum latency is 5 cycles. Each extra slave wait cycle or arbitration-loss cycle adds 1.
- Back-to-back transfers: a new `req_in` is accepted in the IDLE cycle after DONE, so there is at least 1 gap cycle.

## Configuration
- `XBUS_TIMEOUT_EN` defined:
  - An 8-bit counter clears on IDLE→REQ and increments every cycle in REQ or XFER.
  - When counter == `TIMEOUT_CYCLES` and `bus_ack_in`=0, the port moves to DONE with `err_out`=1 and `rdata_out`=0.
  - An ack in the same cycle as the limit wins; no error is flagged.
- `XBUS_TIMEOUT_EN` undefined: no counter, the port waits indefinitely, and `err_out` is tied 0.

## Structure
- Shared defines file: `RstEnable`, `HoldEnable`/`HoldDisable`, `ZeroWord`, state encodings `XBM_IDLE/REQ/XFER/DONE` (2-bit), and the idle master ID 31.
- One sub-module, `xbus_timeout_cnt` (clear, enable, limit → expired). It is instantiated only under `XBUS_TIMEOUT_EN`.

## Test plan
- Read, zero-wait slave: `MASTER_ID`=2, `req_in` with addr 0x0800_0010. Grant arrives cycle 2 and the slave acks cycle 4 with 0xDEADBEEF. Expect `ready_out`=1 at cycle 5, `rdata_out`=0xDEADBEEF, `err_out`=0, `bus_addr_out`=0x0800_0010 from cycles 1-4.
- Write: we=1, wdata 0x1234_5678. Expect `bus_we_out`=1 only in XFER, `bus_data_out`=0x1234_5678, and `ready_out` after ack.
- Grant loss: `bus_master_id_in` switches to 0 during XFER. Expect return to REQ with `bus_req_out` held at 1, and completion after regrant plus ack.
- Timeout with the macro defined, `TIMEOUT_CYCLES`=15, slave never acks: expect `ready_out`=1 and `err_out`=1 exactly 16 cycles after entering REQ. Without the macro, `stall_out` stays 1 indefinitely.
- Reset mid-XFER: expect every output at its reset value on the next edge and no `ready_out` pulse.
- `req_in` toggled with a new address while in REQ: expect the latched address unchanged and the second request ignored.

Source files
------------

// File: rtl/xbus_master_port_pkg.sv
// Shared constants and FSM encoding for the xbus master request port.
package xbus_master_port_pkg;

  localparam logic        RstEnable    = 1'b1;
  localparam logic        HoldEnable   = 1'b1;
  localparam logic        HoldDisable  = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  IdleMasterId = 5'd31;

  typedef enum logic [1:0] {
    XbmIdle = 2'd0,
    XbmReq  = 2'd1,
    XbmXfer = 2'd2,
    XbmDone = 2'd3
  } xbm_state_e;

endpackage

// File: rtl/xbus_timeout_cnt.sv
// 8-bit cycle counter with clear/enable; flags when the count reaches the limit.
module xbus_timeout_cnt
  import xbus_master_port_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      count_q <= 8'd0;
    end else if (clear) begin
      count_q <= 8'd0;
    end else if (enable) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expired = (count_q == limit);

endmodule

// File: rtl/xbus_master_port.sv
// Per-master request port in front of the xbus arbiter: one load/store at a time.
// Define XBUS_TIMEOUT_EN to abort stuck transfers after TIMEOUT_CYCLES with err_out.
module xbus_master_port
  import xbus_master_port_pkg::*;
#(
  parameter int unsigned MASTER_ID      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_in,
  input  logic        we_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall_out,
  output logic        ready_out,
  output logic [31:0] rdata_out,
  output logic        err_out,
  output logic        bus_req_out,
  input  logic [4:0]  bus_master_id_in,
  input  logic        bus_hold_in,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_data_out,
  output logic        bus_we_out,
  input  logic [31:0] bus_data_in,
  input  logic        bus_ack_in
);

  localparam logic [4:0] MyId         = 5'(MASTER_ID);
  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

  xbm_state_e  state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic        we_q, err_q, err_d;
  logic        grant, busy, accept, cnt_enable, timed_out;

  assign grant      = (bus_hold_in == HoldEnable) && (bus_master_id_in == MyId);
  assign busy       = (state_q != XbmIdle);
  assign accept     = (state_q == XbmIdle) && req_in;
  assign cnt_enable = (state_q == XbmReq) || (state_q == XbmXfer);

`ifdef XBUS_TIMEOUT_EN
  logic expired;

  xbus_timeout_cnt u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (cnt_enable),
    .limit   (TimeoutLimit),
    .expired (expired)
  );

  // A same-cycle ack beats the limit.
  assign timed_out = cnt_enable && expired && !bus_ack_in;
`else
  logic unused_timeout;
  assign unused_timeout = ^{TimeoutLimit, cnt_enable};
  assign timed_out      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      XbmIdle: begin
        err_d = 1'b0;
        if (req_in) state_d = XbmReq;
      end
      XbmReq: begin
        if (timed_out) begin
          state_d = XbmDone;
          err_d   = 1'b1;
          rdata_d = ZeroWord;
        end else if (grant) begin
          state_d = XbmXfer;
        end
      end
      XbmXfer: begin
        if (bus_ack_in) begin
          state_d = XbmDone;
          rdata_d = bus_data_in;
        end else if (timed_out) begin
          state_d = XbmDone;
          err_d   = 1'b1;
          rdata_d = ZeroWord;
        end else if (!grant) begin
          // Grant lost: re-arbitrate with the same latched request.
          state_d = XbmReq;
        end
      end
      XbmDone: begin
        err_d   = 1'b0;
        state_d = XbmIdle;
      end
      default: state_d = XbmIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= XbmIdle;
      addr_q  <= ZeroWord;
      wdata_q <= ZeroWord;
      rdata_q <= ZeroWord;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q  <= addr_in;
        wdata_q <= wdata_in;
        we_q    <= we_in;
      end
    end
  end

  assign stall_out    = busy || req_in;
  assign ready_out    = (state_q == XbmDone);
  assign rdata_out    = rdata_q;
  assign err_out      = err_q;
  assign bus_req_out  = cnt_enable;
  assign bus_we_out   = (state_q == XbmXfer) && we_q;
  assign bus_addr_out = busy ? addr_q : ZeroWord;
  assign bus_data_out = busy ? wdata_q : ZeroWord;

endmodule

// File: tb/tb_xbus_master_port.sv
// Randomized self-checking bench for xbus_master_port; the bench plays the bus and slave.
module tb_xbus_master_port;

  localparam int unsigned MyId = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_in, we_in;
  logic [31:0] addr_in, wdata_in;
  logic        stall_out, ready_out, err_out;
  logic [31:0] rdata_out;
  logic        bus_req_out, bus_we_out;
  logic [4:0]  bus_master_id_in;
  logic        bus_hold_in, bus_ack_in;
  logic [31:0] bus_addr_out, bus_data_out, bus_data_in;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xbus_master_port #(
    .MASTER_ID      (MyId),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_in           (req_in),
    .we_in            (we_in),
    .addr_in          (addr_in),
    .wdata_in         (wdata_in),
    .stall_out        (stall_out),
    .ready_out        (ready_out),
    .rdata_out        (rdata_out),
    .err_out          (err_out),
    .bus_req_out      (bus_req_out),
    .bus_master_id_in (bus_master_id_in),
    .bus_hold_in      (bus_hold_in),
    .bus_addr_out     (bus_addr_out),
    .bus_data_out     (bus_data_out),
    .bus_we_out       (bus_we_out),
    .bus_data_in      (bus_data_in),
    .bus_ack_in       (bus_ack_in)
  );

  function automatic logic [4:0] other_id();
    logic [4:0] id;
    id = 5'($urandom_range(0, 31));
    if (id == 5'(MyId)) id = 5'd31;
    return id;
  endfunction

  // Bus side: either grant this master, or show some other (or no) owner.
  task automatic drive_bus(input logic g, input logic ack, input logic [31:0] d);
    if (g) begin
      bus_hold_in      = 1'b1;
      bus_master_id_in = 5'(MyId);
    end else begin
      bus_hold_in      = 1'($urandom_range(0, 1));
      bus_master_id_in = other_id();
    end
    bus_ack_in  = ack;
    bus_data_in = ack ? d : $urandom();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_in = 1'b0;
      drive_bus(1'b0, 1'b0, 32'h0);
    end
  endtask

  // One transfer: grant first visible at cycle 2+l, ack after w slave waits,
  // so ready lands at cycle 5+l+w. Inputs after cycle 0 are junk and must be ignored.
  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int l, input int w);
    int          done_cyc;
    logic [3:0]  exp_ctl, got_ctl;
    logic [63:0] exp_bus, got_bus;
    done_cyc = 5 + l + w;
    for (int c = 0; c <= done_cyc; c++) begin
      @(negedge clk);
      req_in = 1'b1;
      if (c == 0) begin
        we_in = we; addr_in = addr; wdata_in = wdata;
      end else begin
        we_in = 1'($urandom); addr_in = $urandom(); wdata_in = $urandom();
      end
      drive_bus(c >= 2 + l && c < done_cyc, c == 4 + l + w, rdata);
      #1;
      exp_ctl = {c >= 1 && c < done_cyc, we && c >= 3 + l && c < done_cyc,
                 c == done_cyc, 1'b1};
      got_ctl = {bus_req_out, bus_we_out, ready_out, stall_out};
      exp_bus = (c >= 1) ? {addr, wdata} : 64'h0;
      got_bus = {bus_addr_out, bus_data_out};
      n_checks++;
      if ({got_ctl, got_bus} !== {exp_ctl, exp_bus}) begin
        n_fail++;
        $display("FAIL %s cyc %0d: req/we/rdy/stall got %b want %b, addr/data got %h want %h",
                 name, c, got_ctl, exp_ctl, got_bus, exp_bus);
      end
      if (c == done_cyc) begin
        n_checks++;
        if (err_out !== 1'b0 || (!we && rdata_out !== rdata)) begin
          n_fail++;
          $display("FAIL %s completion: err %b rdata %h, want err 0 rdata %h",
                   name, err_out, rdata_out, rdata);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_in = 1'b0; we_in = 1'b1; addr_in = $urandom(); wdata_in = $urandom();
    drive_bus(1'b1, 1'b1, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({stall_out, ready_out, err_out, bus_req_out, bus_we_out, rdata_out, bus_addr_out,
         bus_data_out} !== 101'h0) begin
      n_fail++;
      $display("FAIL reset: stall %b ready %b err %b req %b we %b rdata %h addr %h data %h, want all 0",
               stall_out, ready_out, err_out, bus_req_out, bus_we_out, rdata_out,
               bus_addr_out, bus_data_out);
    end
    rst = 1'b0;
    drive_bus(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_read();
    run_txn("read", 1'b0, 32'h0800_0010, $urandom(), 32'hDEAD_BEEF, 0, 0);
    idle(1);
  endtask

  task automatic test_write();
    run_txn("write", 1'b1, 32'h1000_0004, 32'h1234_5678, $urandom(), 0, 0);
    idle(1);
    run_txn("write_wait", 1'b1, 32'h1800_0100, 32'hCAFE_F00D, $urandom(), 1, 2);
    idle(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_txn("random", 1'($urandom), $urandom(), $urandom(), $urandom(),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
      idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      run_txn("b2b", 1'($urandom), $urandom(), $urandom(), $urandom(), 0,
              int'($urandom_range(0, 1)));
    end
    idle(1);
  endtask

  // Grant at 2 (XFER at 3), lost in 3, regranted in 5 (XFER at 6), ack in 6, ready at 7.
  task automatic test_grant_loss();
    logic [7:0]  req_mask, we_mask;
    logic [31:0] a, d;
    logic [2:0]  exp_v, got_v;
    req_mask = 8'b0111_1110;
    we_mask  = 8'b0100_1000;
    a = $urandom(); d = $urandom();
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      req_in = 1'b1;
      if (c == 0) begin we_in = 1'b1; addr_in = a; wdata_in = d; end
      else begin we_in = 1'b0; addr_in = $urandom(); end
      if (c == 3) begin
        bus_hold_in = 1'b1; bus_master_id_in = 5'd0; bus_ack_in = 1'b0;
      end else begin
        drive_bus(c == 2 || c == 5 || c == 6, c == 6, $urandom());
      end
      #1;
      exp_v = {req_mask[c], we_mask[c], c == 7};
      got_v = {bus_req_out, bus_we_out, ready_out};
      n_checks++;
      if (got_v !== exp_v || (c >= 1 && bus_addr_out !== a)) begin
        n_fail++;
        $display("FAIL grant_loss cyc %0d: req/we/rdy got %b want %b, addr got %h want %h",
                 c, got_v, exp_v, bus_addr_out, a);
      end
    end
    idle(1);
  endtask

  // A second request with a new address issued while in REQ must not disturb the first.
  task automatic test_ignore_req();
    logic [31:0] a;
    int          readies;
    a = 32'h0800_0AA0;
    readies = 0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      req_in  = (c == 0 || (c >= 2 && c <= 7));
      addr_in = (c == 0) ? a : $urandom();
      we_in   = 1'b0;
      drive_bus(c >= 4 && c < 7, c == 6, 32'h5555_AAAA);
      #1;
      if (ready_out === 1'b1) readies++;
      if (c >= 1 && c <= 7) begin
        n_checks++;
        if (bus_addr_out !== a) begin
          n_fail++;
          $display("FAIL ignore_req cyc %0d: addr got %h want %h", c, bus_addr_out, a);
        end
      end
    end
    n_checks++;
    if (readies != 1 || bus_req_out !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_req: ready pulses got %0d want 1, final req got %b want 0",
               readies, bus_req_out);
    end
  endtask

  task automatic test_timeout();
    logic [2:0] exp_v, got_v;
`ifdef XBUS_TIMEOUT_EN
    // REQ entered at cycle 1; limit 15 expires 16 cycles later.
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      req_in = (c == 0); we_in = 1'b0; addr_in = 32'h2000_0000;
      drive_bus(c >= 2, 1'b0, 32'h0);
      #1;
      exp_v = {c >= 1 && c < 17, c == 17, c == 17};
      got_v = {bus_req_out, ready_out, err_out};
      n_checks++;
      if (got_v !== exp_v || (c == 17 && rdata_out !== 32'h0)) begin
        n_fail++;
        $display("FAIL timeout cyc %0d: req/rdy/err got %b want %b, rdata %h", c, got_v, exp_v,
                 rdata_out);
      end
    end
    idle(1);
`else
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      req_in = (c == 0); we_in = 1'b0; addr_in = 32'h2000_0000;
      drive_bus(c >= 2, 1'b0, 32'h0);
      #1;
      exp_v = {c >= 1, 1'b0, 1'b0};
      got_v = {bus_req_out, ready_out, err_out};
      n_checks++;
      if (got_v !== exp_v || stall_out !== 1'b1) begin
        n_fail++;
        $display("FAIL no_timeout cyc %0d: req/rdy/err got %b want %b, stall %b want 1",
                 c, got_v, exp_v, stall_out);
      end
    end
    test_reset();
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    a = 32'h0800_0040;
    run_txn("pre_reset", 1'b0, 32'h0000_0008, 32'h0, 32'hA5A5_A5A5, 0, 0);
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      req_in = (c <= 2); we_in = 1'b1; addr_in = a; wdata_in = 32'h7777_7777;
      rst    = (c == 3);
      drive_bus(c >= 2 && c <= 3, c == 3, 32'h1111_1111);
      #1;
      if (c == 4) begin
        n_checks++;
        if ({stall_out, ready_out, err_out, bus_req_out, bus_we_out, rdata_out, bus_addr_out,
             bus_data_out} !== 101'h0) begin
          n_fail++;
          $display("FAIL reset_mid: stall %b ready %b err %b req %b we %b rdata %h addr %h data %h, want all 0",
                   stall_out, ready_out, err_out, bus_req_out, bus_we_out, rdata_out,
                   bus_addr_out, bus_data_out);
        end
      end else if (c > 4) begin
        n_checks++;
        if (ready_out !== 1'b0 || bus_req_out !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_mid_after cyc %0d: ready %b req %b, want 0 0", c, ready_out,
                   bus_req_out);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_grant_loss();
    test_ignore_req();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
